// File: rtl/adc_sequencer.sv
// SAR ADC conversion sequencer: periodic/manual triggering, rdy handshake, 2^N averaging, valid/ready output.
// Optional conversion watchdog enabled by defining ADC_SEQ_TIMEOUT_EN.
module adc_sequencer #(
  parameter int unsigned RESOLUTION   = 12,
  parameter int unsigned MAX_AVG_LOG2 = 4,
  parameter int unsigned PERIOD_W     = 24,
  parameter int unsigned TIMEOUT_CYC  = 65536
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic                                en_i,
  input  logic [PERIOD_W-1:0]                 period_i,
  input  logic [$clog2(MAX_AVG_LOG2+1)-1:0]   avg_log2_i,
  input  logic                                trig_i,
  input  logic                                clr_i,
  output logic                                adc_start_o,
  input  logic                                adc_rdy_i,
  input  logic [RESOLUTION-1:0]               adc_sample_i,
  output logic [RESOLUTION-1:0]               sample_o,
  output logic                                sample_valid_o,
  input  logic                                sample_ready_i,
  output logic                                busy_o,
  output logic                                overrun_o,
  output logic                                timeout_o
);

  localparam int unsigned AVG_W = $clog2(MAX_AVG_LOG2 + 1);
  localparam int unsigned ACC_W = RESOLUTION + MAX_AVG_LOG2;
  localparam int unsigned CNT_W = MAX_AVG_LOG2 + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_CONV,
    S_ACC,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic              rdy_meta_q, rdy_s_q;
  logic [PERIOD_W-1:0] pcnt_q;
  logic              period_run, tick, trigger;
  logic [AVG_W-1:0]  n_q, n_clamped;
  logic [ACC_W-1:0]  acc_q;
  logic [CNT_W-1:0]  cnt_q, cnt_inc, burst_len;
  logic [RESOLUTION-1:0] sample_q, sample_d;
  logic              valid_q, overrun_q, overrun_set;
  logic              done;
  logic              wd_expire;

  // Two-flop synchronizer; resets to "idle" so a trigger right after reset does not see a stale low.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdy_meta_q <= 1'b1;
      rdy_s_q    <= 1'b1;
    end else begin
      rdy_meta_q <= adc_rdy_i;
      rdy_s_q    <= rdy_meta_q;
    end
  end

  assign period_run = en_i && (period_i != '0);
  assign tick       = period_run && (pcnt_q == period_i - PERIOD_W'(1));
  assign trigger    = tick || trig_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pcnt_q <= '0;
    end else if (!period_run || tick) begin
      pcnt_q <= '0;
    end else begin
      pcnt_q <= pcnt_q + PERIOD_W'(1);
    end
  end

  assign n_clamped = (avg_log2_i > AVG_W'(MAX_AVG_LOG2)) ? AVG_W'(MAX_AVG_LOG2) : avg_log2_i;
  assign cnt_inc   = cnt_q + CNT_W'(1);
  assign burst_len = CNT_W'(1) << n_q;
  assign sample_d  = RESOLUTION'(acc_q >> n_q);
  assign done      = (state_q == S_DONE);
  assign busy_o    = (state_q != S_IDLE);

`ifdef ADC_SEQ_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYC + 1);

  logic [WD_W-1:0] wd_q;
  logic            timeout_q;

  assign wd_expire = ((state_q == S_START) || (state_q == S_CONV)) &&
                     (wd_q == WD_W'(TIMEOUT_CYC - 1));

  // Restarted on every entry to START so the budget applies per conversion, not per burst.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wd_q <= '0;
    end else if ((state_d == S_START) && (state_q != S_START)) begin
      wd_q <= '0;
    end else if ((state_q == S_START) || (state_q == S_CONV)) begin
      wd_q <= wd_q + WD_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= wd_expire || (timeout_q && !clr_i);
    end
  end

  assign timeout_o = timeout_q;
`else
  logic unused_timeout_cfg;

  assign wd_expire          = 1'b0;
  assign timeout_o          = 1'b0;
  assign unused_timeout_cfg = ^TIMEOUT_CYC;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    adc_start_o = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (trigger) state_d = S_START;
      end
      S_START: begin
        adc_start_o = 1'b1;
        if (!rdy_s_q) state_d = S_CONV;
      end
      S_CONV: begin
        if (rdy_s_q) state_d = S_ACC;
      end
      S_ACC: begin
        state_d = (cnt_inc == burst_len) ? S_DONE : S_START;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (wd_expire) begin
      state_d     = S_IDLE;
      adc_start_o = 1'b0;
    end
  end

  // Burst configuration is captured only when leaving IDLE, so mid-burst config changes are ignored.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      n_q   <= '0;
      acc_q <= '0;
      cnt_q <= '0;
    end else if (wd_expire) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (trigger) begin
            n_q   <= n_clamped;
            acc_q <= '0;
            cnt_q <= '0;
          end
        end
        S_ACC: begin
          acc_q <= acc_q + ACC_W'(adc_sample_i);
          cnt_q <= cnt_inc;
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sample_q <= '0;
      valid_q  <= 1'b0;
    end else if (done) begin
      sample_q <= sample_d;
      valid_q  <= 1'b1;
    end else if (valid_q && sample_ready_i) begin
      valid_q  <= 1'b0;
    end
  end

  assign overrun_set = (trigger && busy_o) || (done && valid_q && !sample_ready_i);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= overrun_set || (overrun_q && !clr_i);
    end
  end

  assign sample_o       = sample_q;
  assign sample_valid_o = valid_q;
  assign overrun_o      = overrun_q;

endmodule
